onehot_decoder_pipe: RTL and testbench

ONEHOT_DECODER_PIPE -- requirements
Module: onehot_decoder_pipe

---
 rtl/onehot_decoder_pipe.sv | 146 ++++++++++++++
 tb/tb_onehot_decoder_pipe.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/onehot_decoder_pipe.sv
// onehot_decoder_pipe
//   Decodes a binary index into a one-hot word. The decoded word and its error
//   flag are captured in a 2-entry skid buffer with valid/ready handshakes on
//   both sides.
//
// Parameters
//   WIDTH      one-hot output width (2..256)
//   SIZE       binary index width, defaults to $clog2(WIDTH)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   qualifies in_idx / in_en
//   in_ready   registered; high while a buffer slot is free
//   in_idx     binary index to decode
//   in_en      decode enable; 0 yields an all-zero word with no error
//   out_valid  qualifies out_onehot / out_err
//   out_ready  downstream accept
//   out_onehot decoded word of the oldest buffered item (0 when not valid)
//   out_err    in_idx >= WIDTH for an enabled item (0 when not valid)
//   err_cnt    saturating count of accepted erroneous items
module onehot_decoder_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SIZE  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIZE-1:0]  in_idx,
    input  logic             in_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_onehot,
    output logic             out_err,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] head_word, head_word_nxt;
    logic [WIDTH-1:0] tail_word, tail_word_nxt;
    logic             head_err, head_err_nxt;
    logic             tail_err, tail_err_nxt;
    logic             in_ready_q;
    logic             push, pop;
    logic [WIDTH-1:0] dec_word;
    logic             dec_err;

    // Decode at acceptance time so the buffer holds final output words.
    always_comb begin
        dec_word = '0;
        dec_err  = 1'b0;
        if (in_en) begin
            if (32'(in_idx) >= WIDTH) begin
                dec_err = 1'b1;
            end else begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    dec_word[i] = (32'(in_idx) == i);
                end
            end
        end
    end

    assign push = in_valid && in_ready_q;
    assign pop  = (state != EMPTY) && out_ready;

    always_comb begin
        state_nxt     = state;
        head_word_nxt = head_word;
        head_err_nxt  = head_err;
        tail_word_nxt = tail_word;
        tail_err_nxt  = tail_err;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt     = ONE;
                    head_word_nxt = dec_word;
                    head_err_nxt  = dec_err;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_word_nxt = dec_word;
                    head_err_nxt  = dec_err;
                end else if (push) begin
                    state_nxt     = FULL;
                    tail_word_nxt = dec_word;
                    tail_err_nxt  = dec_err;
                end else if (pop) begin
                    // Clear the head so the outputs read zero while empty.
                    state_nxt     = EMPTY;
                    head_word_nxt = '0;
                    head_err_nxt  = 1'b0;
                end
            end
            FULL: begin
                // in_ready is low in FULL, so only a pop can happen here.
                if (pop) begin
                    state_nxt     = ONE;
                    head_word_nxt = tail_word;
                    head_err_nxt  = tail_err;
                end
            end
            default: begin
                state_nxt     = EMPTY;
                head_word_nxt = '0;
                head_err_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            head_word  <= '0;
            head_err   <= 1'b0;
            tail_word  <= '0;
            tail_err   <= 1'b0;
            in_ready_q <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            head_word  <= head_word_nxt;
            head_err   <= head_err_nxt;
            tail_word  <= tail_word_nxt;
            tail_err   <= tail_err_nxt;
            // Registered from next state: no combinational out_ready->in_ready path.
            in_ready_q <= (state_nxt != FULL);
            if (push && dec_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (state != EMPTY);
    assign out_onehot = head_word;
    assign out_err    = head_err;

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
module tb_onehot_decoder_pipe;

    localparam int unsigned WIDTH = 6;
    localparam int unsigned SIZE  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [SIZE-1:0]  in_idx;
    logic             in_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_onehot;
    logic             out_err;
    logic [7:0]       err_cnt;

    onehot_decoder_pipe #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .in_en      (in_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_err    (out_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    // Reference model: queue of {err, word} in arrival order, plus error tally.
    logic [WIDTH:0] q[$];
    int unsigned    m_cnt;
    bit             m_rst_seen;
    int unsigned    accepted;

    function automatic logic [WIDTH:0] model_decode(int unsigned idx, bit en);
        if (!en)         return '0;
        if (idx >= WIDTH) return {1'b1, {WIDTH{1'b0}}};
        return {1'b0, WIDTH'(1 << idx)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Check all outputs against the model, then advance one clock and update it.
    task automatic cycle();
        bit             exp_ready, push, pop;
        logic [WIDTH:0] front;
        exp_ready = !m_rst_seen && (q.size() < 2);
        front     = (q.size() != 0) ? q[0] : '0;
        chk("out_valid",  32'(out_valid),  32'(q.size() != 0));
        chk("in_ready",   32'(in_ready),   32'(exp_ready));
        chk("out_onehot", 32'(out_onehot), 32'(front[WIDTH-1:0]));
        chk("out_err",    32'(out_err),    32'(front[WIDTH]));
        chk("err_cnt",    32'(err_cnt),    m_cnt);
        push = !rst && in_valid && exp_ready;
        pop  = !rst && (q.size() != 0) && out_ready;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_cnt      = 0;
            m_rst_seen = 1'b1;
        end else begin
            m_rst_seen = 1'b0;
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(model_decode(int'(in_idx), in_en));
                accepted++;
                if (model_decode(int'(in_idx), in_en) >> WIDTH)
                    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            end
        end
        #1;
    endtask

    typedef struct {
        logic [SIZE-1:0]  idx;
        logic             en;
        logic [WIDTH-1:0] exp_word;
        logic             exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{3'd3, 1'b1, 6'b001000, 1'b0};
        vecs[1] = '{3'd0, 1'b1, 6'b000001, 1'b0};
        vecs[2] = '{3'd5, 1'b1, 6'b100000, 1'b0};
        vecs[3] = '{3'd7, 1'b1, 6'b000000, 1'b1};
        vecs[4] = '{3'd7, 1'b0, 6'b000000, 1'b0};
        vecs[5] = '{3'd6, 1'b1, 6'b000000, 1'b1};
        vecs[6] = '{3'd2, 1'b0, 6'b000000, 1'b0};
        vecs[7] = '{3'd1, 1'b1, 6'b000010, 1'b0};

        rst = 1'b1; in_valid = 1'b1; in_idx = 3'd7; in_en = 1'b1; out_ready = 1'b1;
        q.delete(); m_cnt = 0; accepted = 0;
        @(posedge clk); #1;
        m_rst_seen = 1'b1;
        cycle();                    // still in reset: inputs must be ignored
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_err_cnt",  32'(err_cnt),  32'd0);
        rst = 1'b0; in_valid = 1'b0;
        cycle();
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // Table-driven single-item decodes.
        foreach (vecs[i]) begin
            in_valid = 1'b1; in_idx = vecs[i].idx; in_en = vecs[i].en; out_ready = 1'b1;
            cycle();
            in_valid = 1'b0;
            chk("vec_valid", 32'(out_valid),  32'd1);
            chk("vec_word",  32'(out_onehot), 32'(vecs[i].exp_word));
            chk("vec_err",   32'(out_err),    32'(vecs[i].exp_err));
            cycle();
        end
        chk("vec_err_cnt", 32'(err_cnt), 32'd2);

        // Backpressure: two items fill the buffer, third is held off.
        out_ready = 1'b0; in_valid = 1'b1; in_en = 1'b1;
        in_idx = 3'd1; cycle();
        in_idx = 3'd2; cycle();
        chk("full_ready", 32'(in_ready), 32'd0);
        in_idx = 3'd3; cycle();
        chk("held_word", 32'(out_onehot), 32'(6'b000010));
        in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        chk("drain_1", 32'(out_onehot), 32'(6'b000100));
        cycle();
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Back-to-back stream, no bubbles.
        for (int unsigned i = 0; i < WIDTH; i++) begin
            in_valid = 1'b1; in_idx = SIZE'(i); in_en = 1'b1;
            cycle();
            chk("stream_valid", 32'(out_valid),  32'd1);
            chk("stream_word",  32'(out_onehot), 32'(1 << i));
        end
        in_valid = 1'b0;
        cycle();

        // Reset while FULL of erroneous items.
        out_ready = 1'b0; in_valid = 1'b1; in_idx = 3'd7; in_en = 1'b1;
        cycle(); cycle();
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        cycle();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_cnt",   32'(err_cnt),   32'd0);
        chk("mid_rst_ready", 32'(in_ready),  32'd0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        chk("post_rst_ready", 32'(in_ready),  32'd1);
        chk("post_rst_empty", 32'(out_valid), 32'd0);

        // Saturation: 260 erroneous items.
        in_valid = 1'b1; in_idx = 3'd6; in_en = 1'b1;
        for (int unsigned i = 0; i < 260; i++) cycle();
        in_valid = 1'b0;
        cycle();
        chk("sat_cnt", 32'(err_cnt), 32'd255);

        // Randomized traffic against the model.
        rst = 1'b1; cycle(); rst = 1'b0; cycle();
        accepted = 0;
        for (int unsigned c = 0; c < 6000 && accepted < 1000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_idx    = SIZE'($urandom_range(0, 7));
            in_en     = ($urandom_range(0, 4) != 0);
            cycle();
        end
        chk("rand_accepted", (accepted >= 1000) ? 32'd1 : 32'd0, 32'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int unsigned c = 0; c < 4; c++) cycle();
        chk("rand_drained", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
